// File: rtl/controller_sequencer_pkg.sv
// Shared CPU definitions: opcodes, one-hot T-state constants and the control word layout.
package controller_sequencer_pkg;

    localparam int NSTATES_CPU = 6;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
        logic hlt;
    } ctrl_t;

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// One-hot T-state ring: resets to T1 and rotates one position per enabled clock.
module ring_counter #(
    parameter int NSTATES = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance,
    output logic [NSTATES-1:0] t_state
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_state <= {{(NSTATES-1){1'b0}}, 1'b1};
        end else if (advance) begin
            t_state <= {t_state[NSTATES-2:0], t_state[NSTATES-1]};
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// Instruction sequencer: T-state ring plus combinational control-word decode and halt latch.
module controller_sequencer
    import controller_sequencer_pkg::*;
#(
    parameter int NSTATES = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [3:0]         opcode,
    output logic [NSTATES-1:0] t_state,
    output logic               cp,
    output logic               ep,
    output logic               lm,
    output logic               ce,
    output logic               li,
    output logic               ei,
    output logic               la,
    output logic               ea,
    output logic               su,
    output logic               eu,
    output logic               lb,
    output logic               lo,
    output logic               hlt
);

    logic  halted;
    logic  halt_req;
    logic  advance;
    ctrl_t ctrl;

    // HLT in T4 must both raise hlt and stop the ring on the same edge it latches.
    assign halt_req = (t_state == T4) && (opcode == OP_HLT) && !halted;
    assign advance  = run && !halted && !halt_req;

    ring_counter #(
        .NSTATES (NSTATES)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .t_state (t_state)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (halt_req && run) begin
            halted <= 1'b1;
        end
    end

    // Reset gates the decode so T1's ep/lm stay low until reset is released.
    always_comb begin
        ctrl = '0;
        if (reset) begin
            ctrl = '0;
        end else if (halted) begin
            ctrl.hlt = 1'b1;
        end else begin
            case (t_state)
                T1: begin ctrl.ep = 1'b1; ctrl.lm = 1'b1; end
                T2: ctrl.cp = 1'b1;
                T3: begin ctrl.ce = 1'b1; ctrl.li = 1'b1; end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin ctrl.ei = 1'b1; ctrl.lm = 1'b1; end
                        OP_OUT: begin ctrl.ea = 1'b1; ctrl.lo = 1'b1; end
                        OP_HLT: ctrl.hlt = 1'b1;
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin ctrl.ce = 1'b1; ctrl.la = 1'b1; end
                        OP_ADD, OP_SUB: begin ctrl.ce = 1'b1; ctrl.lb = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD: begin ctrl.eu = 1'b1; ctrl.la = 1'b1; end
                        OP_SUB: begin ctrl.eu = 1'b1; ctrl.la = 1'b1; ctrl.su = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign cp  = ctrl.cp;
    assign ep  = ctrl.ep;
    assign lm  = ctrl.lm;
    assign ce  = ctrl.ce;
    assign li  = ctrl.li;
    assign ei  = ctrl.ei;
    assign la  = ctrl.la;
    assign ea  = ctrl.ea;
    assign su  = ctrl.su;
    assign eu  = ctrl.eu;
    assign lb  = ctrl.lb;
    assign lo  = ctrl.lo;
    assign hlt = ctrl.hlt;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: per-cycle expected T-state and control word.
`timescale 1ns/1ps
module tb_controller_sequencer;
    import controller_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic        run;
    logic [3:0]  opcode;
    logic [5:0]  t_state;
    logic        cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
    logic [12:0] ctl;

    int checks = 0;
    int errors = 0;

    int m_idx;
    bit m_halt;

    localparam logic [12:0] B_CP  = 13'd1 << 12;
    localparam logic [12:0] B_EP  = 13'd1 << 11;
    localparam logic [12:0] B_LM  = 13'd1 << 10;
    localparam logic [12:0] B_CE  = 13'd1 << 9;
    localparam logic [12:0] B_LI  = 13'd1 << 8;
    localparam logic [12:0] B_EI  = 13'd1 << 7;
    localparam logic [12:0] B_LA  = 13'd1 << 6;
    localparam logic [12:0] B_EA  = 13'd1 << 5;
    localparam logic [12:0] B_SU  = 13'd1 << 4;
    localparam logic [12:0] B_EU  = 13'd1 << 3;
    localparam logic [12:0] B_LB  = 13'd1 << 2;
    localparam logic [12:0] B_LO  = 13'd1 << 1;
    localparam logic [12:0] B_HLT = 13'd1;

    typedef struct {
        string       tag;
        logic [5:0]  ts;
        logic [12:0] ctl;
    } exp_t;

    exp_t sbq[$];

    controller_sequencer #(.NSTATES(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .opcode  (opcode),
        .t_state (t_state),
        .cp      (cp),
        .ep      (ep),
        .lm      (lm),
        .ce      (ce),
        .li      (li),
        .ei      (ei),
        .la      (la),
        .ea      (ea),
        .su      (su),
        .eu      (eu),
        .lb      (lb),
        .lo      (lo),
        .hlt     (hlt)
    );

    assign ctl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] exp_ctl(input int idx, input logic [3:0] op,
                                            input bit halt, input bit rst);
        if (rst) return 13'd0;
        if (halt) return B_HLT;
        case (idx)
            0: return B_EP | B_LM;
            1: return B_CP;
            2: return B_CE | B_LI;
            3: begin
                if (op == 4'b0000 || op == 4'b0001 || op == 4'b0010) return B_EI | B_LM;
                if (op == 4'b1110) return B_EA | B_LO;
                if (op == 4'b1111) return B_HLT;
                return 13'd0;
            end
            4: begin
                if (op == 4'b0000) return B_CE | B_LA;
                if (op == 4'b0001 || op == 4'b0010) return B_CE | B_LB;
                return 13'd0;
            end
            5: begin
                if (op == 4'b0001) return B_EU | B_LA;
                if (op == 4'b0010) return B_EU | B_LA | B_SU;
                return 13'd0;
            end
            default: return 13'd0;
        endcase
    endfunction

    task automatic cyc(input logic [3:0] op, input logic r, input logic rs, input string tag);
        exp_t e;
        exp_t got;
        int   drivers;
        @(negedge clk);
        opcode = op;
        run    = r;
        reset  = rs;
        #1;
        if (rs) begin
            m_idx  = 0;
            m_halt = 1'b0;
        end
        e.tag = tag;
        e.ts  = 6'd1 << m_idx;
        e.ctl = exp_ctl(m_idx, op, m_halt, rs);
        sbq.push_back(e);
        got = sbq.pop_front();
        chk({got.tag, "_ts"}, 32'(t_state), 32'(got.ts));
        chk({got.tag, "_ctl"}, 32'(ctl), 32'(got.ctl));
        drivers = int'(ep) + int'(ce) + int'(ei) + int'(ea) + int'(eu);
        chk("bus_excl", 32'(drivers <= 1), 32'd1);
        chk("su_without_eu", 32'(su && !eu), 32'd0);
        @(posedge clk);
        if (!reset && !m_halt && run) begin
            if (m_idx == 3 && opcode == 4'b1111) m_halt = 1'b1;
            else m_idx = (m_idx + 1) % 6;
        end
    endtask

    task automatic instr(input logic [3:0] op, input string tag);
        for (int i = 0; i < 6; i++) cyc(op, 1'b1, 1'b0, tag);
    endtask

    initial begin
        logic [3:0] rop;
        logic       rrun;
        logic       rrst;
        opcode = 4'b0000;
        run    = 1'b0;
        reset  = 1'b1;
        m_idx  = 0;
        m_halt = 1'b0;

        cyc(OP_LDA, 1'b1, 1'b1, "rst");
        cyc(OP_LDA, 1'b1, 1'b1, "rst");

        for (int i = 0; i < 7; i++) cyc(OP_LDA, 1'b1, 1'b0, "lda");
        for (int i = 0; i < 5; i++) cyc(4'h5, 1'b1, 1'b0, "pad");

        instr(OP_SUB, "sub");
        instr(OP_ADD, "add");
        instr(OP_OUT, "out");
        instr(4'h5, "nop");

        cyc(OP_LDA, 1'b1, 1'b0, "frz");
        cyc(OP_LDA, 1'b1, 1'b0, "frz");
        for (int i = 0; i < 5; i++) cyc(OP_LDA, 1'b0, 1'b0, "frz_hold");
        for (int i = 0; i < 4; i++) cyc(OP_LDA, 1'b1, 1'b0, "frz_resume");

        for (int i = 0; i < 3; i++) cyc(4'($urandom_range(15)), 1'b1, 1'b0, "fetch_opchg");
        for (int i = 0; i < 3; i++) cyc(OP_ADD, 1'b1, 1'b0, "add_after_chg");

        for (int i = 0; i < 4; i++) cyc(OP_HLT, 1'b1, 1'b0, "hlt_enter");
        for (int i = 0; i < 20; i++) cyc(4'($urandom_range(15)), 1'(i % 2), 1'b0, "halted");
        cyc(OP_LDA, 1'b1, 1'b1, "hlt_rst");
        cyc(OP_LDA, 1'b1, 1'b0, "post_rst");
        for (int i = 0; i < 5; i++) cyc(4'h5, 1'b1, 1'b0, "pad");

        for (int i = 0; i < 4; i++) cyc(OP_ADD, 1'b1, 1'b0, "add_pre_async");
        @(negedge clk);
        opcode = OP_ADD;
        run    = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("async_ts", 32'(t_state), 32'(T1));
        chk("async_ctl", 32'(ctl), 32'd0);
        m_idx  = 0;
        m_halt = 1'b0;
        cyc(OP_ADD, 1'b1, 1'b1, "async_hold");

        for (int i = 0; i < 10000; i++) begin
            rop = 4'($urandom_range(15));
            if (rop == 4'hF && $urandom_range(7) != 0) rop = 4'h5;
            rrun = 1'($urandom_range(3) != 0);
            rrst = 1'($urandom_range(99) == 0);
            cyc(rop, rrun, rrst, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
